ir_multi_detect: RTL and testbench
==================================

// Module: ir_multi_detect
// PURPOSE
//  Parametrised successor of the fixed 3-channel IR threshold/LED logic.
//  Takes NCH packed ADC channel samples from adc_control, together with a new-frame strobe.
//  Produces a debounced per-channel line-detect vector using a hysteresis band (thr_lo..thr_hi).
//  Also produces a one-cycle change pulse and a count of active channels.
//  Sits between adc_control and the LED/steering logic.
// PARAMETERS
//  NCH      3   number of IR channels
//  DW       12  ADC sample width (bits)
//  DEB_CNT  4   consecutive disagreeing valid samples required to flip det[i]; legal range >=1
//  CNTW     $clog2(DEB_CNT+1)  debounce counter width (derived, not for override)
// PORTS
//  clk_50       in   1        system clock, 50 MHz
//  rst_n        in   1        asynchronous active-low reset
//  enable       in   1        1 = detection active; 0 = freeze det, clear debounce counters
//  sample_valid in   1        1-cycle strobe: sample_data holds a fresh frame
//  sample_data  in   NCH*DW   channel i at [i*DW +: DW], unsigned
//  thr_hi       in   DW       set threshold: sample > thr_hi counts as "on" evidence
//  thr_lo       in   DW       clear threshold: sample < thr_lo counts as "off" evidence
//  det          out  NCH      debounced detect state per channel (drives LEDs)
//  det_change   out  1        1-cycle pulse, coincident with any det bit changing
//  active_cnt   out  $clog2(NCH+1)  popcount of det
// BEHAVIOUR
//  Reset (async, rst_n=0): det=0, all cnt[i]=0, det_change=0, active_cnt=0.
//   Release takes effect at the next clk_50 edge.
//  Per channel i, on each rising edge with sample_valid=1 and enable=1:
//   - disagree = det[i] ? (s_i < thr_lo) : (s_i > thr_hi).
//   - Comparisons are strict, unsigned, DW bits.
//   - disagree=0 (including in-band values): cnt[i] <= 0; det[i] holds.
//   - disagree=1 and cnt[i]+1 < DEB_CNT: cnt[i] <= cnt[i]+1.
//   - disagree=1 and cnt[i]+1 == DEB_CNT: det[i] <= ~det[i]; cnt[i] <= 0.
//  sample_valid=0: cnt and det hold; det_change <= 0.
//  enable=0: cnt[i] <= 0 every cycle, det holds, det_change <= 0; sample_valid is ignored.
//  Latency: det[i] updates on the edge that samples the DEB_CNT-th consecutive disagreeing frame.
//   With DEB_CNT=1, det follows on the same edge as the frame.
//  det_change is registered: 1 for exactly the cycle in which the new det is visible.
//   Several channels flipping on one frame give a single pulse.
//  active_cnt is combinational popcount of the det register; it is always consistent with det.
//  thr_lo > thr_hi is legal; the rules above apply unchanged (no hysteresis band).
//   Thresholds are sampled live every cycle; a mid-count change affects only later frames.
//  A counter never exceeds DEB_CNT-1, so no wrap-around occurs.
// TESTING  (NCH=3, DW=12, DEB_CNT=4, thr_hi=2047, thr_lo=1800, enable=1 unless noted)
//  1. Assert rst_n=0 mid-operation with det=3'b101 -> det=0, det_change=0, active_cnt=0 immediately.
//  2. ch0=3000 for 3 frames -> det=000. 4th frame -> det=001, det_change=1 for 1 cycle,
//     active_cnt=1.
//  3. From det[0]=1: ch0=1900 x10 -> det[0] stays 1. ch0=1799 x4 -> det[0]=0 on the 4th frame.
//  4. Glitch: ch1 = 3000,3000,3000,100, then 3000 x3 -> det[1] still 0; one more 3000 -> det[1]=1.
//  5. Boundary: ch2=2047 x8 -> det[2] stays 0. All channels 4095 x4 -> det=111,
//     a single det_change pulse, active_cnt=3.
//  6. Run 3 frames of 3000 on ch0, then enable=0 for 5 cycles, then enable=1 with 3 more frames
//     -> det[0]=0. A 4th frame -> det[0]=1. Gaps in sample_valid between frames do not reset cnt.

Source files
------------

// File: rtl/ir_multi_detect_if.sv
// Handshake/data bundle between adc_control, the IR line detector and the LED/steering logic.
interface ir_multi_detect_if #(
   parameter int NCH = 3,
   parameter int DW  = 12
);
   localparam int ACW = $clog2(NCH+1);

   logic              enable;
   logic              sample_valid;
   logic [NCH*DW-1:0] sample_data;
   logic [DW-1:0]     thr_hi;
   logic [DW-1:0]     thr_lo;
   logic [NCH-1:0]    det;
   logic              det_change;
   logic [ACW-1:0]    active_cnt;

   modport master (
      output enable, sample_valid, sample_data, thr_hi, thr_lo,
      input  det, det_change, active_cnt
   );

   modport slave (
      input  enable, sample_valid, sample_data, thr_hi, thr_lo,
      output det, det_change, active_cnt
   );
endinterface

// File: rtl/ir_multi_detect.sv
// Per-channel hysteresis + debounce line detector with a shared change pulse and active count.
// One ir_ch lane per channel; the top only merges flip strobes and counts set bits.
module ir_ch #(
   parameter int DW      = 12,
   parameter int DEB_CNT = 4,
   parameter int CNTW    = 3
) (
   input  logic          clk_50,
   input  logic          rst_n,
   input  logic          enable,
   input  logic          sample_valid,
   input  logic [DW-1:0] s,
   input  logic [DW-1:0] thr_hi,
   input  logic [DW-1:0] thr_lo,
   output logic          det,
   output logic          flip
);
   localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DEB_CNT-1);

   logic            det_q, det_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic            disagree;

   always_comb begin
      det_d    = det_q;
      cnt_d    = cnt_q;
      flip     = 1'b0;
      // Evidence only counts when it argues against the current state.
      disagree = det_q ? (s < thr_lo) : (s > thr_hi);
      if (!enable) begin
         cnt_d = '0;
      end else if (sample_valid) begin
         if (!disagree) begin
            cnt_d = '0;
         end else if (cnt_q == CNT_LAST) begin
            det_d = ~det_q;
            cnt_d = '0;
            flip  = 1'b1;
         end else begin
            cnt_d = cnt_q + CNTW'(1);
         end
      end
   end

   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         det_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         det_q <= det_d;
         cnt_q <= cnt_d;
      end
   end

   assign det = det_q;
endmodule

module ir_multi_detect #(
   parameter int NCH     = 3,
   parameter int DW      = 12,
   parameter int DEB_CNT = 4,
   parameter int CNTW    = $clog2(DEB_CNT+1)
) (
   input logic              clk_50,
   input logic              rst_n,
   ir_multi_detect_if.slave bus
);
   localparam int ACW = $clog2(NCH+1);

   logic [NCH-1:0] det;
   logic [NCH-1:0] flip;
   logic           det_change_q, det_change_d;
   logic [ACW-1:0] active_cnt;

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      ir_ch #(
         .DW      (DW),
         .DEB_CNT (DEB_CNT),
         .CNTW    (CNTW)
      ) u_ch (
         .clk_50       (clk_50),
         .rst_n        (rst_n),
         .enable       (bus.enable),
         .sample_valid (bus.sample_valid),
         .s            (bus.sample_data[i*DW +: DW]),
         .thr_hi       (bus.thr_hi),
         .thr_lo       (bus.thr_lo),
         .det          (det[i]),
         .flip         (flip[i])
      );
   end

   // Lanes already suppress flips when disabled or idle, so OR-ing them is enough.
   always_comb begin
      det_change_d = |flip;
   end

   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) det_change_q <= 1'b0;
      else        det_change_q <= det_change_d;
   end

   always_comb begin
      active_cnt = '0;
      for (int i = 0; i < NCH; i++) active_cnt = active_cnt + ACW'(det[i]);
   end

   assign bus.det        = det;
   assign bus.det_change = det_change_q;
   assign bus.active_cnt = active_cnt;
endmodule

// File: tb/tb_ir_multi_detect.sv
// Directed scenarios plus randomized frames against a run-length reference model.
module tb_ir_multi_detect;
   localparam int NCH = 3;
   localparam int DW = 12;
   localparam int DEB_CNT = 4;

   logic clk_50 = 1'b0;
   logic rst_n  = 1'b0;
   int   n_pass = 0;
   int   n_tot  = 0;

   bit [NCH-1:0] m_det;
   int           m_run [NCH];

   ir_multi_detect_if #(.NCH(NCH), .DW(DW)) bus ();

   ir_multi_detect #(.NCH(NCH), .DW(DW), .DEB_CNT(DEB_CNT)) dut (
      .clk_50 (clk_50),
      .rst_n  (rst_n),
      .bus    (bus)
   );

   always #10 clk_50 = ~clk_50;

   task automatic chk(input string tag, input int obs, input int exp);
      n_tot++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [NCH*DW-1:0] pk(input int c0, input int c1, input int c2);
      logic [NCH*DW-1:0] d;
      d[0*DW +: DW] = DW'(c0);
      d[1*DW +: DW] = DW'(c1);
      d[2*DW +: DW] = DW'(c2);
      return d;
   endfunction

   function automatic void model_reset();
      m_det = '0;
      for (int c = 0; c < NCH; c++) m_run[c] = 0;
   endfunction

   // One clock: drive, predict, then check #1 after the edge.
   task automatic step(input logic en, input logic vld, input logic [NCH*DW-1:0] d);
      bit chg;
      int s;
      bit against;
      chg = 0;
      bus.enable       = en;
      bus.sample_valid = vld;
      bus.sample_data  = d;
      for (int c = 0; c < NCH; c++) begin
         if (!en) begin
            m_run[c] = 0;
         end else if (vld) begin
            s = int'(d[c*DW +: DW]);
            against = m_det[c] ? (s < int'(bus.thr_lo)) : (s > int'(bus.thr_hi));
            if (against) begin
               m_run[c]++;
               if (m_run[c] == DEB_CNT) begin
                  m_det[c] = ~m_det[c];
                  m_run[c] = 0;
                  chg = 1;
               end
            end else begin
               m_run[c] = 0;
            end
         end
      end
      @(posedge clk_50);
      #1;
      chk("det", int'(bus.det), int'(m_det));
      chk("det_change", int'(bus.det_change), int'(chg));
      chk("active_cnt", int'(bus.active_cnt), $countones(m_det));
   endtask

   task automatic frames(input int n, input logic [NCH*DW-1:0] d);
      for (int k = 0; k < n; k++) step(1'b1, 1'b1, d);
   endtask

   function automatic int rnd_sample(input int lo, input int hi);
      case ($urandom_range(0, 3))
         0: return int'($urandom_range(0, 4095));
         1: return hi - 2 + int'($urandom_range(0, 4));
         2: return lo - 2 + int'($urandom_range(0, 4));
         default: return ($urandom_range(0, 1) != 0) ? 4095 : 0;
      endcase
   endfunction

   initial begin
      int lo;
      int hi;
      bus.enable       = 1'b1;
      bus.sample_valid = 1'b0;
      bus.sample_data  = '0;
      bus.thr_hi       = 12'd2047;
      bus.thr_lo       = 12'd1800;
      model_reset();

      // Reset values
      #15;
      chk("rst_det", int'(bus.det), 0);
      chk("rst_chg", int'(bus.det_change), 0);
      chk("rst_act", int'(bus.active_cnt), 0);
      @(negedge clk_50);
      rst_n = 1'b1;

      // Turn-on after exactly DEB_CNT frames
      frames(3, pk(3000, 1900, 1900));
      chk("t2_det_before", int'(bus.det), 0);
      step(1'b1, 1'b1, pk(3000, 1900, 1900));
      chk("t2_det", int'(bus.det), 1);
      chk("t2_chg", int'(bus.det_change), 1);
      chk("t2_act", int'(bus.active_cnt), 1);
      step(1'b1, 1'b0, pk(0, 0, 0));
      chk("t2_chg_drop", int'(bus.det_change), 0);

      // Hysteresis band holds, then turn-off
      frames(10, pk(1900, 1900, 1900));
      chk("t3_band", int'(bus.det), 1);
      frames(3, pk(1799, 1900, 1900));
      chk("t3_off_before", int'(bus.det), 1);
      step(1'b1, 1'b1, pk(1799, 1900, 1900));
      chk("t3_off", int'(bus.det), 0);

      // Glitch restarts the count
      frames(3, pk(1900, 3000, 1900));
      frames(1, pk(1900, 100, 1900));
      frames(3, pk(1900, 3000, 1900));
      chk("t4_glitch", int'(bus.det), 0);
      step(1'b1, 1'b1, pk(1900, 3000, 1900));
      chk("t4_on", int'(bus.det), 2);

      // Strict threshold boundary, then simultaneous flips
      frames(8, pk(1900, 3000, 2047));
      chk("t5_boundary", int'(bus.det), 2);
      frames(3, pk(4095, 4095, 4095));
      step(1'b1, 1'b1, pk(4095, 4095, 4095));
      chk("t5_all", int'(bus.det), 7);
      chk("t5_chg", int'(bus.det_change), 1);
      chk("t5_act", int'(bus.active_cnt), 3);
      step(1'b1, 1'b1, pk(4095, 4095, 4095));
      chk("t5_single_pulse", int'(bus.det_change), 0);

      // Async reset mid-operation from det=101
      frames(4, pk(4095, 0, 4095));
      chk("t1_pre", int'(bus.det), 5);
      #3;
      rst_n = 1'b0;
      #2;
      model_reset();
      chk("t1_det", int'(bus.det), 0);
      chk("t1_chg", int'(bus.det_change), 0);
      chk("t1_act", int'(bus.active_cnt), 0);
      @(negedge clk_50);
      rst_n = 1'b1;

      // Enable low clears debounce progress; valid gaps do not
      frames(3, pk(3000, 1900, 1900));
      for (int k = 0; k < 5; k++) step(1'b0, 1'b1, pk(3000, 1900, 1900));
      for (int k = 0; k < 3; k++) begin
         step(1'b1, 1'b1, pk(3000, 1900, 1900));
         step(1'b1, 1'b0, pk(0, 0, 0));
      end
      chk("t6_after_en", int'(bus.det), 0);
      step(1'b1, 1'b1, pk(3000, 1900, 1900));
      chk("t6_on", int'(bus.det), 1);

      // Randomized frames, including inverted threshold pairs
      for (int k = 0; k < 600; k++) begin
         if (k % 50 == 0) begin
            bus.thr_hi = DW'($urandom_range(100, 4000));
            bus.thr_lo = DW'($urandom_range(100, 4000));
         end
         hi = int'(bus.thr_hi);
         lo = int'(bus.thr_lo);
         step(($urandom_range(0, 9) != 0), ($urandom_range(0, 9) < 7),
              pk(rnd_sample(lo, hi), rnd_sample(lo, hi), rnd_sample(lo, hi)));
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
